// File: rtl/traffic_phase_scheduler_if.sv
// Handshake bundle between the intersection controller and its surroundings:
// synchronised request/freeze inputs, light heads, phase code and tick status.
interface traffic_phase_scheduler_if;
  logic       farm_req;
  logic       hold;
  logic [2:0] hw_light;
  logic [2:0] farm_light;
  logic [2:0] phase;
  logic       tick;
  logic       req_pending;

  modport master (
    output farm_req, hold,
    input  hw_light, farm_light, phase, tick, req_pending
  );

  modport slave (
    input  farm_req, hold,
    output hw_light, farm_light, phase, tick, req_pending
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Tick-driven highway/farm-road phase scheduler: prescaler, per-state tick timer,
// farm request latch and a six-state light sequencer with Moore outputs.
module traffic_phase_scheduler #(
  parameter int TICK_DIV   = 50000000,
  parameter int GREEN_MIN  = 5,
  parameter int FARM_GREEN = 8,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  traffic_phase_scheduler_if.slave    bus
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]      GMIN_M1  = 8'(GREEN_MIN - 1);
  localparam logic [7:0]      FG_M1    = 8'(FARM_GREEN - 1);
  localparam logic [7:0]      YEL_M1   = 8'(YELLOW_T - 1);
  localparam logic [7:0]      AR_M1    = 8'(ALLRED_T - 1);

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [2:0] {
    ST_HG  = 3'd0,
    ST_HY  = 3'd1,
    ST_AR1 = 3'd2,
    ST_FG  = 3'd3,
    ST_FY  = 3'd4,
    ST_AR2 = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] presc_r;
  logic [CNT_W-1:0] presc_next_s;
  logic [7:0]       timer_r;
  logic [7:0]       timer_next_s;
  logic             req_pending_r;
  logic             req_next_s;
  logic [2:0]       hw_light_r;
  logic [2:0]       farm_light_r;
  logic [2:0]       hw_next_s;
  logic [2:0]       farm_next_s;
  logic             tick_s;
  logic             trans_s;

  // Tick fires on the last prescaler count unless frozen by hold.
  always_comb begin
    tick_s = 1'b0;
    if ((presc_r == CNT_LAST) && !bus.hold) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Next-state logic; every move is gated by a tick except illegal-code recovery.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_HG: begin
        if (tick_s && (timer_r >= GMIN_M1) && (req_pending_r || bus.farm_req)) begin
          state_next_s = ST_HY;
        end else begin
          state_next_s = ST_HG;
        end
      end
      ST_HY: begin
        if (tick_s && (timer_r == YEL_M1)) state_next_s = ST_AR1;
        else                                state_next_s = ST_HY;
      end
      ST_AR1: begin
        if (tick_s && (timer_r == AR_M1)) state_next_s = ST_FG;
        else                               state_next_s = ST_AR1;
      end
      ST_FG: begin
        if (tick_s && (timer_r == FG_M1)) state_next_s = ST_FY;
        else                               state_next_s = ST_FG;
      end
      ST_FY: begin
        if (tick_s && (timer_r == YEL_M1)) state_next_s = ST_AR2;
        else                                state_next_s = ST_FY;
      end
      ST_AR2: begin
        if (tick_s && (timer_r == AR_M1)) state_next_s = ST_HG;
        else                               state_next_s = ST_AR2;
      end
      default: state_next_s = ST_HG;
    endcase
  end

  // Prescaler, timer and request latch next values; the AR1->FG clear beats a set.
  always_comb begin
    trans_s      = (state_next_s != state_r);
    presc_next_s = presc_r;
    timer_next_s = timer_r;
    req_next_s   = req_pending_r;
    if (bus.hold && !trans_s) begin
      presc_next_s = presc_r;
    end else if (trans_s || (presc_r == CNT_LAST)) begin
      presc_next_s = '0;
    end else begin
      presc_next_s = presc_r + CNT_ONE;
    end
    if (trans_s) begin
      timer_next_s = 8'd0;
    end else if (tick_s && (timer_r != 8'hFF)) begin
      timer_next_s = timer_r + 8'd1;
    end else begin
      timer_next_s = timer_r;
    end
    if ((state_r == ST_AR1) && (state_next_s == ST_FG)) begin
      req_next_s = 1'b0;
    end else if (bus.farm_req && ((state_r == ST_HG) || (state_r == ST_HY) ||
                                  (state_r == ST_AR1) || (state_r == ST_AR2))) begin
      req_next_s = 1'b1;
    end else begin
      req_next_s = req_pending_r;
    end
  end

  // Light decode from the next state so the registered heads move with the state.
  always_comb begin
    hw_next_s   = LT_RED;
    farm_next_s = LT_RED;
    case (state_next_s)
      ST_HG:   begin hw_next_s = LT_GRN; farm_next_s = LT_RED; end
      ST_HY:   begin hw_next_s = LT_YEL; farm_next_s = LT_RED; end
      ST_AR1:  begin hw_next_s = LT_RED; farm_next_s = LT_RED; end
      ST_FG:   begin hw_next_s = LT_RED; farm_next_s = LT_GRN; end
      ST_FY:   begin hw_next_s = LT_RED; farm_next_s = LT_YEL; end
      ST_AR2:  begin hw_next_s = LT_RED; farm_next_s = LT_RED; end
      default: begin hw_next_s = LT_GRN; farm_next_s = LT_RED; end
    endcase
  end

  // State and datapath registers with asynchronous reset to highway green.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_HG;
      presc_r       <= '0;
      timer_r       <= 8'd0;
      req_pending_r <= 1'b0;
      hw_light_r    <= LT_GRN;
      farm_light_r  <= LT_RED;
    end else begin
      state_r       <= state_next_s;
      presc_r       <= presc_next_s;
      timer_r       <= timer_next_s;
      req_pending_r <= req_next_s;
      hw_light_r    <= hw_next_s;
      farm_light_r  <= farm_next_s;
    end
  end

  assign bus.hw_light    = hw_light_r;
  assign bus.farm_light  = farm_light_r;
  assign bus.phase       = state_r;
  assign bus.tick        = tick_s;
  assign bus.req_pending = req_pending_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench: directed test-plan scenarios plus random request/hold
// traffic, all compared cycle by cycle against a tick-arithmetic reference model.
module tb_traffic_phase_scheduler;

  localparam int TICK_DIV   = 4;
  localparam int GREEN_MIN  = 5;
  localparam int FARM_GREEN = 8;
  localparam int YELLOW_T   = 3;
  localparam int ALLRED_T   = 1;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   last_cyc;

  // reference model: phase index, non-held cycles spent in phase, latch
  int   m_ph;
  int   m_active;
  int   m_req;

  logic [2:0] obs_phase;
  logic [2:0] obs_hw;
  logic [2:0] obs_farm;
  logic       obs_tick;
  logic       obs_req;

  logic [2:0] hw_tbl   [6];
  logic [2:0] farm_tbl [6];

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .TICK_DIV  (TICK_DIV),
    .GREEN_MIN (GREEN_MIN),
    .FARM_GREEN(FARM_GREEN),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", tag, last_cyc, obs, exp);
    end
  endtask

  function automatic int dur_of(input int ph);
    case (ph)
      1, 4:    return YELLOW_T;
      2, 5:    return ALLRED_T;
      3:       return FARM_GREEN;
      default: return GREEN_MIN;
    endcase
  endfunction

  // One clock cycle: drive inputs, sample at negedge, compare, advance the model.
  task automatic step(input logic fr, input logic hd);
    int  ticks;
    bit  m_tick;
    bit  leave;
    bus.farm_req = fr;
    bus.hold     = hd;
    @(negedge clk);
    last_cyc  = cyc;
    obs_phase = bus.phase;
    obs_hw    = bus.hw_light;
    obs_farm  = bus.farm_light;
    obs_tick  = bus.tick;
    obs_req   = bus.req_pending;
    m_tick = !hd && ((m_active % TICK_DIV) == TICK_DIV - 1);
    check_val("phase", 32'(obs_phase), 32'(m_ph));
    check_val("hw_light", 32'(obs_hw), 32'(hw_tbl[m_ph]));
    check_val("farm_light", 32'(obs_farm), 32'(farm_tbl[m_ph]));
    check_val("req_pending", 32'(obs_req), 32'(m_req));
    check_val("tick", 32'(obs_tick), 32'(m_tick));
    check_val("both_non_red", 32'((obs_hw != 3'b100) && (obs_farm != 3'b100)), 32'd0);
    ticks = m_active / TICK_DIV;
    if (m_ph == 0) leave = m_tick && (ticks >= GREEN_MIN - 1) && ((m_req != 0) || fr);
    else           leave = m_tick && (ticks == dur_of(m_ph) - 1);
    if (m_ph == 2 && leave)                                   m_req = 0;
    else if (fr && (m_ph == 0 || m_ph == 1 || m_ph == 2 || m_ph == 5)) m_req = 1;
    if (leave) begin
      m_ph     = (m_ph + 1) % 6;
      m_active = 0;
    end else if (!hd) begin
      m_active++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset pulse between edges; checks the immediate reset outputs.
  task automatic do_reset();
    bus.farm_req = 1'b0;
    bus.hold     = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    last_cyc = cyc;
    check_val("rst_phase", 32'(bus.phase), 32'd0);
    check_val("rst_hw", 32'(bus.hw_light), 32'h1);
    check_val("rst_farm", 32'(bus.farm_light), 32'h4);
    check_val("rst_req", 32'(bus.req_pending), 32'd0);
    check_val("rst_tick", 32'(bus.tick), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    m_ph     = 0;
    m_active = 0;
    m_req    = 0;
    cyc      = 0;
  endtask

  initial begin
    int hg_run;
    hw_tbl   = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    farm_tbl = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    last_cyc = 0;
    reset = 1'b1;
    bus.farm_req = 1'b0;
    bus.hold = 1'b0;
    m_ph = 0;
    m_active = 0;
    m_req = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // idle: highway green forever, tick every fourth cycle from cycle 3
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b0);
      if (last_cyc < 12) check_val("s1_tick", 32'(obs_tick), 32'((last_cyc % 4) == 3));
    end
    check_val("s1_phase", 32'(obs_phase), 32'd0);

    // early request pulse at cycle 2
    do_reset();
    for (int i = 0; i < 90; i++) begin
      step(cyc == 2, 1'b0);
      case (last_cyc)
        2:  check_val("s2_req2", 32'(obs_req), 32'd0);
        3:  check_val("s2_req3", 32'(obs_req), 32'd1);
        19: check_val("s2_hg19", 32'(obs_phase), 32'd0);
        20: check_val("s2_hy20", 32'(obs_phase), 32'd1);
        32: check_val("s2_ar32", 32'(obs_phase), 32'd2);
        36: begin
          check_val("s2_fg36", 32'(obs_phase), 32'd3);
          check_val("s2_req36", 32'(obs_req), 32'd0);
        end
        67: check_val("s2_fg67", 32'(obs_phase), 32'd3);
        68: check_val("s2_fy68", 32'(obs_phase), 32'd4);
        80: check_val("s2_ar80", 32'(obs_phase), 32'd5);
        84: check_val("s2_hg84", 32'(obs_phase), 32'd0);
        default: ;
      endcase
    end

    // hold for ten cycles in farm green pushes FY entry from 68 to 78
    do_reset();
    for (int i = 0; i < 90; i++) begin
      step(cyc == 2, (cyc >= 40) && (cyc < 50));
      case (last_cyc)
        43: check_val("s4_tick_held", 32'(obs_tick), 32'd0);
        45: check_val("s4_farm_hold", 32'(obs_farm), 32'h1);
        68: check_val("s4_fg68", 32'(obs_phase), 32'd3);
        77: check_val("s4_fg77", 32'(obs_phase), 32'd3);
        78: check_val("s4_fy78", 32'(obs_phase), 32'd4);
        default: ;
      endcase
    end

    // late request in a long-settled highway green
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step(cyc == 50, 1'b0);
      case (last_cyc)
        51: check_val("s3_hg51", 32'(obs_phase), 32'd0);
        52: check_val("s3_hy52", 32'(obs_phase), 32'd1);
        default: ;
      endcase
    end

    // reset mid farm-yellow, then first tick at cycle 3
    do_reset();
    for (int i = 0; i < 72; i++) step(cyc == 2, 1'b0);
    check_val("s5_in_fy", 32'(obs_phase), 32'd4);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check_val("s5_tick", 32'(obs_tick), 32'(last_cyc == 3));
    end

    // continuous request: each highway green lasts exactly 20 cycles
    do_reset();
    hg_run = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0);
      if (obs_phase == 3'd0) begin
        hg_run++;
      end else if (hg_run > 0) begin
        check_val("s6_hg_len", 32'(hg_run), 32'd20);
        hg_run = 0;
      end
    end

    // random request/hold traffic with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
